// File: rtl/ahb3lite_interconnect_slave_port.sv
// ----------------------------------------------------------------------------
// ahb3lite_interconnect_slave_port
//
// Slave-side stage of the AHB3-Lite multi-layer switch. There is one instance
// per AHB slave, and it sits downstream of every master port. The block
// arbitrates between the master ports that select this slave, muxes the
// address-phase owner's command onto the slave bus, and tracks which master
// owns the data phase so that the correct write data is forwarded. Read data
// and the ready/response signals are broadcast back to all master ports.
//
// Ports
//   HCLK, HRESETn        clock (rising edge), asynchronous active-low reset
//   mstpriority[m]       per-master priority (unsigned, 0 is lowest)
//   mstHSEL[m]           per-master request for this slave
//   mstH*[m]             per-master address-phase command and write data
//   mstHREADY[m]         per-master HREADY (reserved, not used)
//   mstHRDATA            slave read data, broadcast to every master
//   mstHREADYOUT         slave HREADYOUT, broadcast to every master
//   mstHRESP             slave HRESP, broadcast to every master
//   can_switch[m]        the owner may release the bus on the next edge
//   master_granted       one-hot address-phase owner
//   slv_H*               AHB slave bus (command out, response in)
//   slv_HREADY           bus HREADY seen by the slave
// ----------------------------------------------------------------------------
module ahb3lite_interconnect_slave_port #(
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int MASTERS     = 3,
  parameter int MASTER_BITS = $clog2(MASTERS + 1)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,

  // Master-port side
  input  logic [MASTER_BITS-1:0] mstpriority  [MASTERS],
  input  logic [MASTERS-1:0]     mstHSEL,
  input  logic [HADDR_SIZE-1:0]  mstHADDR     [MASTERS],
  input  logic [HDATA_SIZE-1:0]  mstHWDATA    [MASTERS],
  input  logic [MASTERS-1:0]     mstHWRITE,
  input  logic [2:0]             mstHSIZE     [MASTERS],
  input  logic [2:0]             mstHBURST    [MASTERS],
  input  logic [3:0]             mstHPROT     [MASTERS],
  input  logic [1:0]             mstHTRANS    [MASTERS],
  input  logic [MASTERS-1:0]     mstHMASTLOCK,
  input  logic [MASTERS-1:0]     mstHREADY,
  output logic [HDATA_SIZE-1:0]  mstHRDATA,
  output logic                   mstHREADYOUT,
  output logic                   mstHRESP,

  input  logic [MASTERS-1:0]     can_switch,
  output logic [MASTERS-1:0]     master_granted,

  // Slave side
  output logic                   slv_HSEL,
  output logic [HADDR_SIZE-1:0]  slv_HADDR,
  output logic [HDATA_SIZE-1:0]  slv_HWDATA,
  output logic                   slv_HWRITE,
  output logic [2:0]             slv_HSIZE,
  output logic [2:0]             slv_HBURST,
  output logic [3:0]             slv_HPROT,
  output logic [1:0]             slv_HTRANS,
  output logic                   slv_HMASTLOCK,
  input  logic [HDATA_SIZE-1:0]  slv_HRDATA,
  input  logic                   slv_HREADYOUT,
  input  logic                   slv_HRESP,
  output logic                   slv_HREADY
);

  localparam int          OWNER_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1;
  localparam int unsigned NM         = MASTERS;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_t;

  logic [OWNER_BITS-1:0] addr_owner_q, addr_owner_d;
  logic [OWNER_BITS-1:0] data_owner_q, data_owner_d;
  logic                  data_valid_q, data_valid_d;

  logic [MASTERS-1:0]    req;
  logic                  switch_ok;
  logic [OWNER_BITS-1:0] winner;

  // --------------------------------------------------------------------------
  // Address-phase mux: the owner's command goes straight to the slave. An
  // owner that is parked without selecting this slave presents IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    slv_HSEL      = mstHSEL[addr_owner_q];
    slv_HTRANS    = mstHSEL[addr_owner_q] ? mstHTRANS[addr_owner_q] : HTRANS_IDLE;
    slv_HADDR     = mstHADDR[addr_owner_q];
    slv_HWRITE    = mstHWRITE[addr_owner_q];
    slv_HSIZE     = mstHSIZE[addr_owner_q];
    slv_HBURST    = mstHBURST[addr_owner_q];
    slv_HPROT     = mstHPROT[addr_owner_q];
    slv_HMASTLOCK = mstHMASTLOCK[addr_owner_q];
    slv_HREADY    = slv_HREADYOUT;
  end

  // Data phase and response path
  always_comb begin
    slv_HWDATA   = mstHWDATA[data_owner_q];
    mstHRDATA    = slv_HRDATA;
    mstHREADYOUT = slv_HREADYOUT;
    mstHRESP     = slv_HRESP;
  end

  always_comb begin
    master_granted               = '0;
    master_granted[addr_owner_q] = 1'b1;
  end

  // --------------------------------------------------------------------------
  // Arbitration
  // Candidates are visited starting at owner+1 and wrapping, with the current
  // owner visited last. Only a strictly higher priority replaces the running
  // choice, so the first requester in that order wins a tie; this gives
  // round-robin among equals and lets an equal-priority requester displace
  // the owner.
  // --------------------------------------------------------------------------
  assign req       = mstHSEL;
  assign switch_ok = slv_HREADYOUT & (~req[addr_owner_q] | can_switch[addr_owner_q]);

  always_comb begin
    logic                   found;
    logic [MASTER_BITS-1:0] best_prio;
    logic [OWNER_BITS-1:0]  cand;

    found     = 1'b0;
    best_prio = '0;
    cand      = '0;
    winner    = addr_owner_q;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = OWNER_BITS'((32'(addr_owner_q) + k) % NM);
      if (req[cand] && (!found || (mstpriority[cand] > best_prio))) begin
        found     = 1'b1;
        best_prio = mstpriority[cand];
        winner    = cand;
      end
    end
  end

  always_comb begin
    addr_owner_d = addr_owner_q;
    data_owner_d = data_owner_q;
    data_valid_d = data_valid_q;

    // No requests: the bus stays parked on the last owner.
    if (switch_ok && |req) begin
      addr_owner_d = winner;
    end

    // Address phase advances into the data phase only on a ready cycle, so
    // the data owner is frozen through wait states.
    if (slv_HREADYOUT) begin
      data_owner_d = addr_owner_q;
      data_valid_d = slv_HSEL & (slv_HTRANS != HTRANS_IDLE);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_owner_q <= '0;
      data_owner_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      addr_owner_q <= addr_owner_d;
      data_owner_q <= data_owner_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Tracked for completeness of the data-phase state; no output depends on it.
  logic unused_ok;
  assign unused_ok = ^{1'b0, mstHREADY, data_valid_q};

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_port.sv
module tb_ahb3lite_interconnect_slave_port;

  localparam int M = 3;
  localparam int PB = $clog2(M + 1);

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b1;
  logic [PB-1:0] mstpriority [M];
  logic [M-1:0]  mstHSEL;
  logic [31:0]   mstHADDR [M];
  logic [31:0]   mstHWDATA [M];
  logic [M-1:0]  mstHWRITE;
  logic [2:0]    mstHSIZE [M];
  logic [2:0]    mstHBURST [M];
  logic [3:0]    mstHPROT [M];
  logic [1:0]    mstHTRANS [M];
  logic [M-1:0]  mstHMASTLOCK;
  logic [M-1:0]  mstHREADY;
  logic [31:0]   mstHRDATA;
  logic          mstHREADYOUT;
  logic          mstHRESP;
  logic [M-1:0]  can_switch;
  logic [M-1:0]  master_granted;
  logic          slv_HSEL;
  logic [31:0]   slv_HADDR;
  logic [31:0]   slv_HWDATA;
  logic          slv_HWRITE;
  logic [2:0]    slv_HSIZE;
  logic [2:0]    slv_HBURST;
  logic [3:0]    slv_HPROT;
  logic [1:0]    slv_HTRANS;
  logic          slv_HMASTLOCK;
  logic [31:0]   slv_HRDATA;
  logic          slv_HREADYOUT;
  logic          slv_HRESP;
  logic          slv_HREADY;

  int tests_run = 0;
  int tests_failed = 0;

  ahb3lite_interconnect_slave_port #(
    .HADDR_SIZE(32),
    .HDATA_SIZE(32),
    .MASTERS   (M)
  ) dut (
    .HCLK          (HCLK),
    .HRESETn       (HRESETn),
    .mstpriority   (mstpriority),
    .mstHSEL       (mstHSEL),
    .mstHADDR      (mstHADDR),
    .mstHWDATA     (mstHWDATA),
    .mstHWRITE     (mstHWRITE),
    .mstHSIZE      (mstHSIZE),
    .mstHBURST     (mstHBURST),
    .mstHPROT      (mstHPROT),
    .mstHTRANS     (mstHTRANS),
    .mstHMASTLOCK  (mstHMASTLOCK),
    .mstHREADY     (mstHREADY),
    .mstHRDATA     (mstHRDATA),
    .mstHREADYOUT  (mstHREADYOUT),
    .mstHRESP      (mstHRESP),
    .can_switch    (can_switch),
    .master_granted(master_granted),
    .slv_HSEL      (slv_HSEL),
    .slv_HADDR     (slv_HADDR),
    .slv_HWDATA    (slv_HWDATA),
    .slv_HWRITE    (slv_HWRITE),
    .slv_HSIZE     (slv_HSIZE),
    .slv_HBURST    (slv_HBURST),
    .slv_HPROT     (slv_HPROT),
    .slv_HTRANS    (slv_HTRANS),
    .slv_HMASTLOCK (slv_HMASTLOCK),
    .slv_HRDATA    (slv_HRDATA),
    .slv_HREADYOUT (slv_HREADYOUT),
    .slv_HRESP     (slv_HRESP),
    .slv_HREADY    (slv_HREADY)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic set_prio(input int p0, input int p1, input int p2);
    mstpriority[0] = PB'(p0);
    mstpriority[1] = PB'(p1);
    mstpriority[2] = PB'(p2);
  endtask

  initial begin
    for (int i = 0; i < M; i++) begin
      mstpriority[i] = '0;
      mstHWDATA[i]   = 32'hD000_0000 + 32'(i);
      mstHSIZE[i]    = 3'b010;
      mstHBURST[i]   = 3'b000;
      mstHPROT[i]    = 4'b0001;
      mstHTRANS[i]   = 2'b10;
    end
    mstHADDR[0]   = 32'h0000_0300;
    mstHADDR[1]   = 32'h0000_0200;
    mstHADDR[2]   = 32'h0000_0100;
    mstHSIZE[2]   = 3'b001;
    mstHPROT[2]   = 4'b0011;
    mstHSEL       = '0;
    mstHWRITE     = '0;
    mstHMASTLOCK  = '0;
    mstHREADY     = '1;
    can_switch    = '0;
    slv_HRDATA    = 32'h1234_5678;
    slv_HREADYOUT = 1'b1;
    slv_HRESP     = 1'b1;

    // Reset state
    #2 HRESETn = 1'b0;
    #1;
    check("rst_grant", 64'(master_granted), 64'b001);
    check("rst_hsel", 64'(slv_HSEL), 64'd0);
    check("rst_htrans_idle", 64'(slv_HTRANS), 64'b00);
    check("rst_hwdata", 64'(slv_HWDATA), 64'hD000_0000);
    check("hrdata_pass", 64'(mstHRDATA), 64'h1234_5678);
    check("hresp_pass", 64'(mstHRESP), 64'd1);
    slv_HRESP = 1'b0;
    step();
    HRESETn = 1'b1;
    step();
    step();
    check("park_after_rst", 64'(master_granted), 64'b001);

    // Priority: m2 (prio 3) beats m1 (prio 1) while idle owner m0 lets go
    set_prio(0, 1, 3);
    mstHSEL = 3'b110;
    #1;
    check("prio_pre_grant", 64'(master_granted), 64'b001);
    check("prio_pre_htrans", 64'(slv_HTRANS), 64'b00);
    step();
    check("prio_grant", 64'(master_granted), 64'b100);
    check("prio_haddr", 64'(slv_HADDR), 64'h100);
    check("prio_htrans", 64'(slv_HTRANS), 64'b10);
    check("prio_hsize", 64'(slv_HSIZE), 64'b001);
    check("prio_hprot", 64'(slv_HPROT), 64'b0011);
    check("prio_hwdata_m0", 64'(slv_HWDATA), 64'hD000_0000);
    step();
    check("prio_hold_nosw", 64'(master_granted), 64'b100);
    check("prio_hwdata_m2", 64'(slv_HWDATA), 64'hD000_0002);

    // Round-robin among equal priorities
    set_prio(2, 2, 2);
    mstHSEL = 3'b111;
    can_switch = 3'b111;
    step();
    check("rr_wrap_to_m0", 64'(master_granted), 64'b001);
    step();
    check("rr_1", 64'(master_granted), 64'b010);
    step();
    check("rr_2", 64'(master_granted), 64'b100);
    step();
    check("rr_3", 64'(master_granted), 64'b001);
    step();
    check("rr_4", 64'(master_granted), 64'b010);

    // Locked INCR4 on m0 holds off higher-priority m2
    set_prio(1, 0, 3);
    mstHSEL = 3'b001;
    step();
    check("lock_own_m0", 64'(master_granted), 64'b001);
    mstHBURST[0] = 3'b011;
    mstHMASTLOCK[0] = 1'b1;
    mstHSEL = 3'b101;
    can_switch = 3'b000;
    #1;
    check("lock_hburst", 64'(slv_HBURST), 64'b011);
    check("lock_hmastlock", 64'(slv_HMASTLOCK), 64'd1);
    for (int b = 0; b < 3; b++) begin
      step();
      check($sformatf("lock_hold_%0d", b), 64'(master_granted), 64'b001);
    end
    can_switch[0] = 1'b1;
    #1;
    check("lock_release_pre", 64'(master_granted), 64'b001);
    step();
    check("lock_release", 64'(master_granted), 64'b100);
    mstHMASTLOCK[0] = 1'b0;
    mstHBURST[0] = 3'b000;

    // Wait states during an m1 write data phase
    mstHWRITE[1] = 1'b1;
    mstHSEL = 3'b010;
    can_switch = 3'b111;
    step();
    check("ws_own_m1", 64'(master_granted), 64'b010);
    check("ws_hwrite", 64'(slv_HWRITE), 64'd1);
    step();
    check("ws_data_m1", 64'(slv_HWDATA), 64'hD000_0001);
    slv_HREADYOUT = 1'b0;
    mstHSEL = 3'b101;
    #1;
    check("ws_hreadyout", 64'(mstHREADYOUT), 64'd0);
    check("ws_hready", 64'(slv_HREADY), 64'd0);
    for (int w = 0; w < 2; w++) begin
      step();
      check($sformatf("ws_grant_%0d", w), 64'(master_granted), 64'b010);
      check($sformatf("ws_hwdata_%0d", w), 64'(slv_HWDATA), 64'hD000_0001);
      check($sformatf("ws_readyout_%0d", w), 64'(mstHREADYOUT), 64'd0);
    end
    slv_HREADYOUT = 1'b1;
    step();
    check("ws_after_grant", 64'(master_granted), 64'b100);
    check("ws_after_hwdata", 64'(slv_HWDATA), 64'hD000_0001);

    // Parking on m1, then zero-latency re-request
    mstHSEL = 3'b010;
    step();
    check("park_own_m1", 64'(master_granted), 64'b010);
    mstHSEL = 3'b000;
    step();
    step();
    check("park_grant", 64'(master_granted), 64'b010);
    check("park_htrans", 64'(slv_HTRANS), 64'b00);
    check("park_hsel", 64'(slv_HSEL), 64'd0);
    mstHSEL = 3'b010;
    #1;
    check("park_rereq_hsel", 64'(slv_HSEL), 64'd1);
    check("park_rereq_htrans", 64'(slv_HTRANS), 64'b10);
    check("park_rereq_haddr", 64'(slv_HADDR), 64'h200);

    // Reset asserted mid-transfer
    step();
    check("midrst_pre_hwdata", 64'(slv_HWDATA), 64'hD000_0001);
    HRESETn = 1'b0;
    #1;
    check("midrst_grant", 64'(master_granted), 64'b001);
    check("midrst_hwdata", 64'(slv_HWDATA), 64'hD000_0000);
    mstHSEL = 3'b000;
    step();
    HRESETn = 1'b1;
    step();
    step();
    check("midrst_park", 64'(master_granted), 64'b001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
